equation1_solver: RTL and testbench
===================================

# equation1_solver

Hint/auto-solve engine for the equation-1 game. Given the target value (the ongoing timer value the checker compares against), it searches for operands X, Y, Z satisfying Y/Z + (X/Z)^2 = Target under the checker's 8-bit arithmetic. It then drives X, Y, Z onto the checker's data/go interface using the same press/release handshake a player produces with the switches and key. It is the transmitting end of the checker's operand-entry protocol.

## Interface
Parameters:
- PULSE_LEN, 4: cycles for each handshake phase (setup, press, release); must be at least 1.

Ports:
- Clock  in  1  system clock.
- Reset  in  1  asynchronous, active-high reset.
- start  in  1  level; sampled in IDLE only.
- Target  in  7  target value; latched on start.
- Seed  in  8  first X candidate; latched on start; 0 is treated as 1.
- DataOut  out  8  operand presented to checker DataIn.
- Go  out  1  active-high press strobe to checker Go.
- StartEq1  out  1  held high from first SETUP through last RELEASE.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after Z transmission completes.
- fail  out  1  one-cycle pulse when the search space is exhausted.
- err  out  1  sticky self-check mismatch; exists only with the macro.

## Operation
- States: IDLE, SEARCH, CHECK (macro only), SETUP, PRESS, RELEASE, DONE, FAIL.
- IDLE: when start=1, latch Target, Seed→xs (0→1), load X=xs, Z=2, xcnt=0, go to SEARCH.
- SEARCH evaluates one (X, Z) candidate per cycle, all 8-bit unsigned:
  - q = (X/Z * X/Z) mod 256
  - valid iff q ≤ Target and (Target−q)*Z ≤ 255 (9+ bit compare) and (Target−q)*Z ≠ 0
  - On valid: Y = (Target−q)*Z; latch X, Y, Z; go to CHECK (macro) or SETUP.
  - On invalid: X increments with wrap 255→1 (0 skipped), and xcnt increments.
  - When xcnt reaches 254 (255 candidates tried): xcnt=0, X=xs, Z increments.
  - An invalid candidate at Z=255 with xcnt=254 goes to FAIL.
- Transmission uses slot index k=0,1,2 carrying X, Y, Z:
  - SETUP: DataOut valid, Go=0.
  - PRESS: Go=1, DataOut held.
  - RELEASE: Go=0, DataOut held.
  - Each phase lasts PULSE_LEN cycles.
  - After RELEASE: k<2 → k+1 and SETUP; k=2 → DONE.
- DONE and FAIL pulse their flag for one cycle, then return to IDLE.
- start is ignored outside IDLE. Target and Seed changes after latching are ignored.

## Timing
- Reset (async): state IDLE; DataOut, Go, StartEq1, busy, done, fail, err all 0; internal registers 0.
- Outputs are registered. busy rises the cycle after start is sampled.
- Search latency: n cycles for a hit on the n-th candidate. Worst case is 254*255 = 64770 cycles, then FAIL.
- CHECK adds 1 cycle.
- Transmission takes 9*PULSE_LEN cycles. done is asserted in the cycle after the final RELEASE cycle.
- DataOut changes only on entry to SETUP, so it is stable at least PULSE_LEN cycles before each Go rise and through its fall.
- Reset mid-transmission drops Go and StartEq1 asynchronously.

## Configuration
- EQ1_SOLVER_SELFCHECK_EN defined:
  - CHECK state recomputes (Y/Z) + ((X/Z)*(X/Z) mod 256), mod 256.
  - On a mismatch with Target, err is set (sticky until Reset); transmission proceeds regardless.
- Undefined: CHECK state and err port are absent; SEARCH goes directly to SETUP.

## Structure
- Package eq1_pkg:
  - state enum
  - operand width (8) and target width (7)
  - Z_START=2
  - X_SPAN=255
- Sub-module eq1_candidate: combinational evaluator, inputs (X, Z, Target) → (valid, Y). The same evaluator is reused by the CHECK computation.

## Test plan
- Target=5, Seed=1, PULSE_LEN=4 → hit on first candidate: X=1, Y=10, Z=2; done after 1+36 cycles.
- Target=100, Seed=4 → X=4, Y=192, Z=2 (q=4).
- Target=127, Seed=255 → X=255, Y=252, Z=2 (255/2=127, 127² mod 256=1). Seed=0 → X=1, Y=254, Z=2.
- PULSE_LEN=2, Target=5, Seed=1:
  - DataOut=1 for cycles 1–6 with Go=1 on cycles 3–4.
  - Then DataOut=10, then DataOut=2.
  - StartEq1 high throughout all three slots.
- Target=0 → no valid Y; fail pulses after 64770 search cycles; Go never asserted.
- Reset asserted during PRESS of slot Y → Go, StartEq1, busy=0 immediately; a new start restarts the search cleanly. With the macro defined, err stays 0 on all hits above.

Source files
------------

// File: rtl/eq1_pkg.sv
// Shared types and constants for the equation-1 auto-solver.
// Operand/target widths, search start point and per-Z candidate span.
package eq1_pkg;

   localparam int OP_W   = 8;
   localparam int TGT_W  = 7;
   localparam int X_SPAN = 255;

   localparam logic [OP_W-1:0] Z_START = 8'd2;

   typedef enum logic [2:0] {
      IDLE,
      SEARCH,
      CHECK,
      SETUP,
      PRESS,
      RELEASE,
      DONE,
      FAIL
   } state_t;

endpackage

// File: rtl/eq1_candidate.sv
// Combinational evaluator for one (X, Z) candidate in the checker's 8-bit arithmetic.
// Exposes the wrapped square q only when EQ1_SOLVER_SELFCHECK_EN is defined.
module eq1_candidate
   import eq1_pkg::*;
(
   input  logic [OP_W-1:0]  x,
   input  logic [OP_W-1:0]  z,
   input  logic [TGT_W-1:0] target,
   output logic             valid,
   output logic [OP_W-1:0]  y
`ifdef EQ1_SOLVER_SELFCHECK_EN
   ,
   output logic [OP_W-1:0]  q
`endif
);

   logic [OP_W-1:0]   quo;
   logic [OP_W-1:0]   sq;
   logic [OP_W-1:0]   tgt;
   logic [OP_W-1:0]   diff;
   logic [2*OP_W-1:0] prod;

   always_comb begin
      tgt  = {1'b0, target};
      quo  = x / z;
      sq   = quo * quo;
      diff = tgt - sq;
      // Product kept wide so an over-range Y is rejected rather than wrapped.
      prod  = {{OP_W{1'b0}}, diff} * {{OP_W{1'b0}}, z};
      valid = (sq <= tgt) && (prod <= 16'd255) && (prod != '0);
      y     = prod[OP_W-1:0];
   end

`ifdef EQ1_SOLVER_SELFCHECK_EN
   assign q = sq;
`endif

endmodule

// File: rtl/equation1_solver.sv
// Searches X,Z (then Y) so Y/Z + (X/Z)^2 mod 256 = Target, then replays X,Y,Z over the Go handshake.
// One candidate per cycle, 9*PULSE_LEN cycles to transmit; no backpressure, start is only heard in IDLE.
// EQ1_SOLVER_SELFCHECK_EN adds a CHECK state and a sticky err output.
module equation1_solver
   import eq1_pkg::*;
#(
   parameter int PULSE_LEN = 4
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic             start,
   input  logic [TGT_W-1:0] Target,
   input  logic [OP_W-1:0]  Seed,
   output logic [OP_W-1:0]  DataOut,
   output logic             Go,
   output logic             StartEq1,
   output logic             busy,
   output logic             done,
   output logic             fail
`ifdef EQ1_SOLVER_SELFCHECK_EN
   ,
   output logic             err
`endif
);

   localparam int PW = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;
   localparam logic [PW-1:0]   P_LAST    = PW'(PULSE_LEN - 1);
   localparam logic [OP_W-1:0] XCNT_LAST = OP_W'(X_SPAN - 1);

   state_t           state, state_n;
   logic [TGT_W-1:0] target_r, target_n;
   logic [OP_W-1:0]  xs_r, xs_n, x_r, x_n, y_r, y_n, z_r, z_n;
   logic [OP_W-1:0]  xcnt_r, xcnt_n;
   logic [1:0]       k_r, k_n;
   logic [PW-1:0]    pcnt_r, pcnt_n;
   logic [OP_W-1:0]  dout_n, slot, seed_fix;
   logic             go_n, se_n, busy_n, done_n, fail_n;
   logic             cand_valid;
   logic [OP_W-1:0]  cand_y;
`ifdef EQ1_SOLVER_SELFCHECK_EN
   logic [OP_W-1:0]  cand_q, chk_sum;
   logic             err_n;
`endif

   eq1_candidate u_cand (
      .x      (x_r),
      .z      (z_r),
      .target (target_r),
      .valid  (cand_valid),
      .y      (cand_y)
`ifdef EQ1_SOLVER_SELFCHECK_EN
      ,
      .q      (cand_q)
`endif
   );

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state    <= IDLE;
         target_r <= '0;
         xs_r     <= '0;
         x_r      <= '0;
         y_r      <= '0;
         z_r      <= '0;
         xcnt_r   <= '0;
         k_r      <= '0;
         pcnt_r   <= '0;
         DataOut  <= '0;
         Go       <= 1'b0;
         StartEq1 <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         fail     <= 1'b0;
`ifdef EQ1_SOLVER_SELFCHECK_EN
         err      <= 1'b0;
`endif
      end else begin
         state    <= state_n;
         target_r <= target_n;
         xs_r     <= xs_n;
         x_r      <= x_n;
         y_r      <= y_n;
         z_r      <= z_n;
         xcnt_r   <= xcnt_n;
         k_r      <= k_n;
         pcnt_r   <= pcnt_n;
         DataOut  <= dout_n;
         Go       <= go_n;
         StartEq1 <= se_n;
         busy     <= busy_n;
         done     <= done_n;
         fail     <= fail_n;
`ifdef EQ1_SOLVER_SELFCHECK_EN
         err      <= err_n;
`endif
      end
   end

   always_comb begin
      state_n  = state;
      target_n = target_r;
      xs_n     = xs_r;
      x_n      = x_r;
      y_n      = y_r;
      z_n      = z_r;
      xcnt_n   = xcnt_r;
      k_n      = k_r;
      pcnt_n   = pcnt_r;
      seed_fix = (Seed == '0) ? 8'd1 : Seed;
`ifdef EQ1_SOLVER_SELFCHECK_EN
      chk_sum  = (y_r / z_r) + cand_q;
      err_n    = err;
`endif

      case (state)
         IDLE: begin
            if (start) begin
               target_n = Target;
               xs_n     = seed_fix;
               x_n      = seed_fix;
               z_n      = Z_START;
               xcnt_n   = '0;
               state_n  = SEARCH;
            end
         end
         SEARCH: begin
            if (cand_valid) begin
               y_n    = cand_y;
               k_n    = 2'd0;
               pcnt_n = '0;
`ifdef EQ1_SOLVER_SELFCHECK_EN
               state_n = CHECK;
`else
               state_n = SETUP;
`endif
            end else if (xcnt_r == XCNT_LAST) begin
               // All X tried for this Z: rewind X to the seed and move to the next divisor.
               if (z_r == '1) begin
                  state_n = FAIL;
               end else begin
                  xcnt_n = '0;
                  x_n    = xs_r;
                  z_n    = z_r + 8'd1;
               end
            end else begin
               x_n    = (x_r == '1) ? 8'd1 : x_r + 8'd1;
               xcnt_n = xcnt_r + 8'd1;
            end
         end
`ifdef EQ1_SOLVER_SELFCHECK_EN
         CHECK: begin
            err_n   = err | (chk_sum != {1'b0, target_r});
            state_n = SETUP;
         end
`endif
         SETUP, PRESS, RELEASE: begin
            if (pcnt_r == P_LAST) begin
               pcnt_n = '0;
               if (state == SETUP) begin
                  state_n = PRESS;
               end else if (state == PRESS) begin
                  state_n = RELEASE;
               end else if (k_r == 2'd2) begin
                  state_n = DONE;
               end else begin
                  k_n     = k_r + 2'd1;
                  state_n = SETUP;
               end
            end else begin
               pcnt_n = pcnt_r + PW'(1);
            end
         end
         default: state_n = IDLE;
      endcase

      if (k_n == 2'd0)
         slot = x_n;
      else if (k_n == 2'd1)
         slot = y_n;
      else
         slot = z_n;

      // Operand only moves on SETUP entry so it is settled well before Go rises.
      dout_n = DataOut;
      if (state_n == SETUP && state != SETUP)
         dout_n = slot;

      go_n   = (state_n == PRESS);
      se_n   = (state_n == SETUP) || (state_n == PRESS) || (state_n == RELEASE);
      busy_n = (state_n != IDLE);
      done_n = (state_n == DONE);
      fail_n = (state_n == FAIL);
   end

endmodule

// File: tb/tb_equation1_solver.sv
// Scoreboard bench: expected operands queued at start, popped on each Go press.
module tb_equation1_solver;

   logic       Clock = 1'b0;
   logic       Reset;
   logic       start4, start2;
   logic [6:0] Target;
   logic [7:0] Seed;
   logic [7:0] d4, d2;
   logic       go4, go2, se4, se2, busy4, busy2, done4, done2, fail4, fail2;
`ifdef EQ1_SOLVER_SELFCHECK_EN
   logic       err4, err2;
   localparam int CHK_EXTRA = 1;
`else
   localparam int CHK_EXTRA = 0;
`endif

   int total = 0;
   int bad   = 0;
   int exp4[$];
   int exp2[$];
   int presses4 = 0;
   int presses2 = 0;
   logic go4_prev = 1'b0;
   logic go2_prev = 1'b0;

   typedef struct {
      int t; int s; int x; int y; int z; int n;
   } vec_t;

   vec_t tbl[6] = '{
      '{5,   1,   1,   10,  2, 1},
      '{100, 4,   4,   192, 2, 1},
      '{127, 255, 255, 252, 2, 1},
      '{127, 0,   1,   254, 2, 1},
      '{3,   4,   32,  6,   2, 29},
      '{1,   226, 1,   2,   2, 31}
   };

   always #5 Clock = ~Clock;

   equation1_solver #(.PULSE_LEN(4)) dut (
      .Clock    (Clock),
      .Reset    (Reset),
      .start    (start4),
      .Target   (Target),
      .Seed     (Seed),
      .DataOut  (d4),
      .Go       (go4),
      .StartEq1 (se4),
      .busy     (busy4),
      .done     (done4),
      .fail     (fail4)
`ifdef EQ1_SOLVER_SELFCHECK_EN
      ,
      .err      (err4)
`endif
   );

   equation1_solver #(.PULSE_LEN(2)) dut2 (
      .Clock    (Clock),
      .Reset    (Reset),
      .start    (start2),
      .Target   (Target),
      .Seed     (Seed),
      .DataOut  (d2),
      .Go       (go2),
      .StartEq1 (se2),
      .busy     (busy2),
      .done     (done2),
      .fail     (fail2)
`ifdef EQ1_SOLVER_SELFCHECK_EN
      ,
      .err      (err2)
`endif
   );

   task automatic chk(input string tag, input int obs, input int exp);
      total = total + 1;
      if (obs != exp) begin
         bad = bad + 1;
         $display("FAIL %s: got %0d want %0d", tag, obs, exp);
      end
   endtask

   always @(negedge Clock) begin
      if (go4 && !go4_prev) begin
         presses4 = presses4 + 1;
         if (exp4.size() == 0)
            chk("press4_unexpected", d4, -1);
         else
            chk("press4_data", d4, exp4.pop_front());
      end
      go4_prev = go4;
   end

   always @(negedge Clock) begin
      if (go2 && !go2_prev) begin
         presses2 = presses2 + 1;
         if (exp2.size() == 0)
            chk("press2_unexpected", d2, -1);
         else
            chk("press2_data", d2, exp2.pop_front());
      end
      go2_prev = go2;
   end

   task automatic run4(input vec_t v);
      int cyc = 0;
      @(negedge Clock);
      Target = 7'(v.t);
      Seed   = 8'(v.s);
      start4 = 1'b1;
      exp4.push_back(v.x);
      exp4.push_back(v.y);
      exp4.push_back(v.z);
      @(negedge Clock);
      start4 = 1'b0;
      chk("busy_rise", busy4, 1);
      Target = 7'(v.t + 9);
      Seed   = 8'(v.s + 3);
      while (!done4 && cyc < 70000) begin
         @(negedge Clock);
         cyc++;
      end
      chk("latency", cyc, v.n + 36 + CHK_EXTRA);
      chk("done_flag", done4, 1);
      @(negedge Clock);
      chk("done_pulse", done4, 0);
      chk("busy_idle", busy4, 0);
      chk("se_idle", se4, 0);
      chk("queue4_empty", exp4.size(), 0);
   endtask

   initial begin
      int cyc;
      int p0;
      int vals[3];
      vals = '{1, 10, 2};
      Reset  = 1'b1;
      start4 = 1'b0;
      start2 = 1'b0;
      Target = '0;
      Seed   = '0;
      repeat (2) @(negedge Clock);
      chk("rst_data", d4, 0);
      chk("rst_go", go4, 0);
      chk("rst_se", se4, 0);
      chk("rst_busy", busy4, 0);
      chk("rst_done", done4, 0);
      chk("rst_fail", fail4, 0);
      Reset = 1'b0;

      foreach (tbl[i]) run4(tbl[i]);

      // Handshake shape on the short-pulse instance.
      @(negedge Clock);
      Target = 7'd5;
      Seed   = 8'd1;
      start2 = 1'b1;
      exp2.push_back(1);
      exp2.push_back(10);
      exp2.push_back(2);
      @(negedge Clock);
      start2 = 1'b0;
      chk("p2_search_se", se2, 0);
      @(negedge Clock);
      if (CHK_EXTRA == 1) @(negedge Clock);
      for (int i = 1; i <= 18; i++) begin
         chk("p2_data", d2, vals[(i - 1) / 6]);
         chk("p2_go", go2, (((i - 1) % 6) == 2 || ((i - 1) % 6) == 3) ? 1 : 0);
         chk("p2_se", se2, 1);
         @(negedge Clock);
      end
      chk("p2_done", done2, 1);
      chk("p2_se_off", se2, 0);
      chk("queue2_empty", exp2.size(), 0);

      // Exhaustive search with no solution.
      p0  = presses4;
      cyc = 0;
      @(negedge Clock);
      Target = 7'd0;
      Seed   = 8'd1;
      start4 = 1'b1;
      @(negedge Clock);
      start4 = 1'b0;
      while (!fail4 && !done4 && cyc < 70000) begin
         @(negedge Clock);
         cyc++;
      end
      chk("fail_latency", cyc, 64770);
      chk("fail_flag", fail4, 1);
      chk("fail_no_done", done4, 0);
      @(negedge Clock);
      chk("fail_pulse", fail4, 0);
      chk("fail_busy", busy4, 0);
      chk("fail_no_go", presses4 - p0, 0);

      // Reset in the middle of the Y press, then a clean restart.
      p0  = presses4;
      cyc = 0;
      @(negedge Clock);
      Target = 7'd100;
      Seed   = 8'd4;
      start4 = 1'b1;
      exp4.push_back(4);
      exp4.push_back(192);
      @(negedge Clock);
      start4 = 1'b0;
      while (!(presses4 - p0 == 2 && go4) && cyc < 200) begin
         @(negedge Clock);
         cyc++;
      end
      chk("rst_reach_press", presses4 - p0, 2);
      #1 Reset = 1'b1;
      #1;
      chk("rst_mid_go", go4, 0);
      chk("rst_mid_se", se4, 0);
      chk("rst_mid_busy", busy4, 0);
      @(negedge Clock);
      Reset = 1'b0;
      exp4.delete();
      run4(tbl[0]);
`ifdef EQ1_SOLVER_SELFCHECK_EN
      chk("err4_clear", err4, 0);
      chk("err2_clear", err2, 0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
